// File: rtl/read_fanin_pkg.sv
// rtl/read_fanin_pkg.sv - shared types and helpers for the read fan-in register block
//
// Purpose: APB request record and register reset-value helper shared by the
//          register block and its read mux.
// Contents:
//   MAX_DATA_W / MAX_ADDR_W  widest data/address the request record can carry
//   apb_req_t                captured setup-phase request {addr, write, wdata, strb}
//   reset_value(i)           power-on value of register i (i+1)

package read_fanin_pkg;

  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_ADDR_W = 32;

  // Sized for the widest configuration; narrower blocks fill the low bits and
  // leave the rest zero.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0]   addr;
    logic                    write;
    logic [MAX_DATA_W-1:0]   wdata;
    logic [MAX_DATA_W/8-1:0] strb;
  } apb_req_t;

  // Distinct non-zero reset values make a stuck or mis-decoded register obvious.
  function automatic logic [MAX_DATA_W-1:0] reset_value(input int unsigned i);
    return MAX_DATA_W'(i + 1);
  endfunction

endpackage

// File: rtl/read_fanin_mux.sv
// rtl/read_fanin_mux.sv - one-hot select, AND-OR reduction read mux
//
// Purpose: merges N register values onto one bus. Each input is gated by its
//          one-hot select bit and all gated inputs are ORed; no priority chain.
//          An all-zero select yields zero.
// Ports:
//   din   in   N x W   register values
//   sel   in   N       one-hot select (all-zero allowed)
//   dout  out  W       selected value

module read_fanin_mux #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 32
) (
  input  logic [N-1:0][W-1:0] din,
  input  logic [N-1:0]        sel,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      dout = dout | (din[i] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/read_fanin_regblock.sv
// rtl/read_fanin_regblock.sv - APB4 register block with wide AND-OR read fan-in
//
// Purpose: N_REGS read/write registers of REGWIDTH bits at consecutive word
//          addresses behind an APB4 slave. Zero-wait-state: the request is taken
//          on the setup-phase edge and pready is registered for the first
//          access-phase cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_apb_psel      select
//   s_apb_penable   access phase
//   s_apb_pwrite    1=write, 0=read
//   s_apb_pprot     protection (ignored)
//   s_apb_paddr     byte address
//   s_apb_pwdata    write data
//   s_apb_pstrb     byte write strobes
//   s_apb_pready    transfer complete (one cycle)
//   s_apb_prdata    read data (zero outside a read response)
//   s_apb_pslverr   index beyond N_REGS

module read_fanin_regblock
  import read_fanin_pkg::*;
#(
  parameter int unsigned REGWIDTH     = 32,
  parameter int unsigned N_REGS       = 1,
  parameter int unsigned G_ADDR_WIDTH = $clog2(N_REGS) + $clog2(REGWIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_apb_psel,
  input  logic                      s_apb_penable,
  input  logic                      s_apb_pwrite,
  input  logic [2:0]                s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]   s_apb_paddr,
  input  logic [REGWIDTH-1:0]       s_apb_pwdata,
  input  logic [REGWIDTH/8-1:0]     s_apb_pstrb,
  output logic                      s_apb_pready,
  output logic [REGWIDTH-1:0]       s_apb_prdata,
  output logic                      s_apb_pslverr
);

  localparam int unsigned NBYTES = REGWIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = (G_ADDR_WIDTH > OFF_W) ? (G_ADDR_WIDTH - OFF_W) : 1;

  apb_req_t                         req;
  logic                             setup;
  logic [IDX_W-1:0]                 idx;
  logic [N_REGS-1:0]                sel;
  logic                             idx_err;
  logic [N_REGS-1:0][REGWIDTH-1:0]  regs;
  logic [REGWIDTH-1:0]              rd_mux;
  logic                             unused_inputs;

  always_comb begin
    req                          = '0;
    req.addr[G_ADDR_WIDTH-1:0]   = s_apb_paddr;
    req.write                    = s_apb_pwrite;
    req.wdata[REGWIDTH-1:0]      = s_apb_pwdata;
    req.strb[NBYTES-1:0]         = s_apb_pstrb;
  end

  assign setup = s_apb_psel & ~s_apb_penable;

  // Byte-offset bits are dropped, so unaligned addresses hit the containing word.
  if (G_ADDR_WIDTH > OFF_W) begin : g_idx
    assign idx = req.addr[G_ADDR_WIDTH-1:OFF_W];
  end else begin : g_idx_single
    assign idx = '0;
  end

  // Out-of-range indices decode to an all-zero select: no register is written
  // and the mux returns zero without extra gating.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      sel[i] = (32'(idx) == i);
    end
  end

  assign idx_err = (32'(idx) >= N_REGS);

  read_fanin_mux #(
    .N (N_REGS),
    .W (REGWIDTH)
  ) u_mux (
    .din  (regs),
    .sel  (sel),
    .dout (rd_mux)
  );

  // Reads sample the register array at the setup edge; writes land on the same
  // edge, so any transfer whose setup follows sees the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs[i] <= REGWIDTH'(reset_value(i));
      end
      s_apb_pready  <= 1'b0;
      s_apb_prdata  <= '0;
      s_apb_pslverr <= 1'b0;
    end else begin
      s_apb_pready  <= setup;
      s_apb_pslverr <= setup & idx_err;
      s_apb_prdata  <= (setup && !req.write) ? rd_mux : '0;
      if (setup && req.write) begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
          for (int unsigned k = 0; k < NBYTES; k++) begin
            if (sel[i] && req.strb[k]) begin
              regs[i][k*8 +: 8] <= req.wdata[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  assign unused_inputs = ^{s_apb_pprot, req};

endmodule

// File: tb/tb_read_fanin_regblock.sv
// tb/tb_read_fanin_regblock.sv - directed bench for the read fan-in register block

module tb_read_fanin_regblock;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel64 = 1'b0;
  logic        psel5 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  pprot = 3'b000;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  logic        pready64, pslverr64, pready5, pslverr5;
  logic [31:0] prdata64, prdata5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  read_fanin_regblock #(.REGWIDTH(32), .N_REGS(64)) dut64 (
    .clk           (clk),
    .rst           (rst),
    .s_apb_psel    (psel64),
    .s_apb_penable (penable),
    .s_apb_pwrite  (pwrite),
    .s_apb_pprot   (pprot),
    .s_apb_paddr   (paddr),
    .s_apb_pwdata  (pwdata),
    .s_apb_pstrb   (pstrb),
    .s_apb_pready  (pready64),
    .s_apb_prdata  (prdata64),
    .s_apb_pslverr (pslverr64)
  );

  read_fanin_regblock #(.REGWIDTH(32), .N_REGS(5)) dut5 (
    .clk           (clk),
    .rst           (rst),
    .s_apb_psel    (psel5),
    .s_apb_penable (penable),
    .s_apb_pwrite  (pwrite),
    .s_apb_pprot   (pprot),
    .s_apb_paddr   (paddr[4:0]),
    .s_apb_pwdata  (pwdata),
    .s_apb_pstrb   (pstrb),
    .s_apb_pready  (pready5),
    .s_apb_prdata  (prdata5),
    .s_apb_pslverr (pslverr5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer on dut 64 or dut 5; leaves the bus in the access
  // phase so a following call forms a back-to-back transfer.
  task automatic xfer(input string tag, input int d, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] sb,
                      input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    psel64 = (d == 64); psel5 = (d == 5);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = sb;
    @(negedge clk);
    check({tag, ".setup_ready"}, (d == 64) ? pready64 : pready5, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check({tag, ".ready"}, (d == 64) ? pready64 : pready5, 32'd1);
    check({tag, ".rdata"}, (d == 64) ? prdata64 : prdata5, exp_rd);
    check({tag, ".err"},   (d == 64) ? pslverr64 : pslverr5, 32'(exp_err));
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    psel64 = 1'b0; psel5 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check({tag, ".ready64"}, pready64, 32'd0);
    check({tag, ".ready5"},  pready5,  32'd0);
    check({tag, ".rdata64"}, prdata64, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready",  pready64,  32'd0);
    check("rst.rdata",  prdata64,  32'd0);
    check("rst.err",    pslverr64, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      xfer($sformatf("rd%0d", i), 64, 1'b0, 8'(i * 4), 32'h0, 4'h0, 32'(i + 1), 1'b0);
    end
    idle("after_rd_all");

    xfer("wr5", 64, 1'b1, 8'h14, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    idle("after_wr5");
    xfer("rd5", 64, 1'b0, 8'h14, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    xfer("rd4", 64, 1'b0, 8'h10, 32'h0, 4'h0, 32'h00000005, 1'b0);
    xfer("rd6", 64, 1'b0, 8'h18, 32'h0, 4'h0, 32'h00000007, 1'b0);
    xfer("rd5_unaligned", 64, 1'b0, 8'h17, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    xfer("wr2_strb", 64, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xfer("rd2_strb", 64, 1'b0, 8'h08, 32'h0, 4'h0, 32'h00BB00DD, 1'b0);
    xfer("wr2_hi",   64, 1'b1, 8'h0B, 32'h11223344, 4'b1000, 32'h0, 1'b0);
    xfer("rd2_hi",   64, 1'b0, 8'h08, 32'h0, 4'h0, 32'h11BB00DD, 1'b0);
    idle("after_strb");

    xfer("n5_rd4",      5, 1'b0, 8'h10, 32'h0, 4'h0, 32'h00000005, 1'b0);
    xfer("n5_rd_oor",   5, 1'b0, 8'h18, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer("n5_wr_oor",   5, 1'b1, 8'h18, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xfer("n5_rd_oor7",  5, 1'b0, 8'h1C, 32'h0, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      xfer($sformatf("n5_rd%0d", i), 5, 1'b0, 8'(i * 4), 32'h0, 4'h0, 32'(i + 1), 1'b0);
    end
    idle("after_n5");

    @(posedge clk); #1;
    psel64 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("abort.ready", pready64, 32'd0);
    check("abort.rdata", prdata64, 32'd0);
    @(posedge clk); #1;
    psel64 = 1'b0; penable = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("abort.ready_after", pready64, 32'd0);
    xfer("abort.rd0", 64, 1'b0, 8'h00, 32'h0, 4'h0, 32'h00000001, 1'b0);
    xfer("abort.rd5", 64, 1'b0, 8'h14, 32'h0, 4'h0, 32'h00000006, 1'b0);
    idle("after_abort");

    xfer("b2b_wr63", 64, 1'b1, 8'hFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xfer("b2b_rd63", 64, 1'b0, 8'hFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    xfer("b2b_rd62", 64, 1'b0, 8'hF8, 32'h0, 4'h0, 32'h0000003F, 1'b0);
    idle("after_b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
